hamming74_encoder_tx: RTL and testbench

- Transmit-side counterpart of the 7-bit decoder project: accepts 4-bit data nibbles over a valid/ready handshake and Hamming(7,4)-encodes them.
- Optional single-bit error injection per nibble, so the downstream decoder's correction path can be exercised.
- Buffers codewords in a small FIFO and serializes each as a framed single-wire stream (start, 7 bits LSB-first, stop).
- Sits in the user project area, driving the wire the decoder samples.

---
 rtl/ham74_pkg.sv | 41 ++++
 rtl/ham74_sync_fifo.sv | 47 ++++
 rtl/hamming74_encoder_tx.sv | 114 +++++++++++
 tb/tb_hamming74_encoder_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ham74_pkg.sv
// rtl/ham74_pkg.sv - shared Hamming(7,4) constants, FSM states and encoder function
package ham74_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  localparam logic [2:0] ERR_NONE = 3'd7;

  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P3 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // err_pos 0..6 flips that codeword bit so the decoder's correction path can be exercised
  function automatic logic [CODE_W-1:0] ham74_encode(input logic [DATA_W-1:0] d,
                                                      input logic [2:0]        err_pos);
    logic [CODE_W-1:0] c;
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_D0] = d[0];
    c[POS_P3] = d[1] ^ d[2] ^ d[3];
    c[POS_D1] = d[1];
    c[POS_D2] = d[2];
    c[POS_D3] = d[3];
    if (err_pos != ERR_NONE) begin
      c[err_pos] = ~c[err_pos];
    end
    return c;
  endfunction

endpackage

// File: rtl/ham74_sync_fifo.sv
// rtl/ham74_sync_fifo.sv - synchronous FIFO with wrap-bit pointers
module ham74_sync_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // full is derived from registered pointers only, so a same-cycle pop never frees a slot early
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/hamming74_encoder_tx.sv
// rtl/hamming74_encoder_tx.sv - Hamming(7,4) encoder with error injection and framed serial transmitter
module hamming74_encoder_tx
  import ham74_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [2:0]       err_pos,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(CODE_W - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [CODE_W-1:0] sreg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CODE_W-1:0] fifo_dout;
  logic [CODE_W-1:0] codeword;

  assign in_ready = rst_n && !fifo_full;
  assign codeword = ham74_encode(in_data, err_pos);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  ham74_sync_fifo #(
    .DATA_W (CODE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (codeword),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // tx is driven from the state held during the edge, so the line lags the FSM by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx          <= 1'b1;
      baud        <= '0;
      bit_idx     <= '0;
      sreg        <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            sreg  <= fifo_dout;
            baud  <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          tx <= 1'b0;
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          tx <= sreg[bit_idx];
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          tx <= 1'b1;
          if (baud == BAUD_LAST) begin
            baud        <= '0;
            frames_sent <= frames_sent + 1'b1;
            state       <= ST_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// tb/tb_hamming74_encoder_tx.sv - self-checking bench for hamming74_encoder_tx
module tb_hamming74_encoder_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int FRAME = 9 * CPB;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [2:0]       err_pos;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;

  hamming74_encoder_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .err_pos     (err_pos),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit saw_not_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Parity built from codeword positions 1..7: parity at 2^j covers positions with bit j set
  function automatic int data_pos(input int i);
    return (i == 0) ? 3 : (i == 1) ? 5 : (i == 2) ? 6 : 7;
  endfunction

  function automatic logic [6:0] model_encode(input logic [3:0] d, input logic [2:0] ep);
    logic [6:0] c;
    logic       par;
    c = '0;
    for (int i = 0; i < 4; i++) c[data_pos(i) - 1] = d[i];
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++) begin
        if (((p >> j) & 1) == 1 && p != 1 && p != 2 && p != 4) par = par ^ c[p - 1];
      end
      c[(1 << j) - 1] = par;
    end
    if (ep != 3'd7) c[ep] = ~c[ep];
    return c;
  endfunction

  // Frame timing model: each accepted nibble gets a start edge s; its line cells follow s
  int         cyc = 0;
  bit         model_on = 1'b0;
  int         model_fs;
  int         last_start;
  int         q_s[$];
  logic [6:0] q_c[$];

  always @(posedge clk) begin
    int e;
    int occ;
    int s;
    cyc++;
    e = cyc;
    if (!rst_n) begin
      q_s.delete();
      q_c.delete();
      model_fs   = 0;
      last_start = -100000;
      model_on   = 1'b1;
    end else if (model_on) begin
      occ = 0;
      foreach (q_s[i]) if (q_s[i] - 1 > e - 1) occ++;
      if (in_valid && occ < DEPTH) begin
        s = (e + 2 > last_start + FRAME + 1) ? e + 2 : last_start + FRAME + 1;
        q_s.push_back(s);
        q_c.push_back(model_encode(in_data, err_pos));
        last_start = s;
      end
      while (q_s.size() > 0 && q_s[0] + FRAME - 1 <= e) begin
        void'(q_s.pop_front());
        void'(q_c.pop_front());
        model_fs++;
      end
    end
  end

  always @(negedge clk) begin
    logic       exp_tx;
    logic [6:0] cw;
    int         idx;
    int         occ;
    if (model_on) begin
      exp_tx = 1'b1;
      if (q_s.size() > 0 && q_s[0] <= cyc) begin
        idx = (cyc - q_s[0]) / CPB;
        cw  = q_c[0];
        if (idx == 0) exp_tx = 1'b0;
        else if (idx <= 7) exp_tx = cw[idx - 1];
      end
      occ = 0;
      foreach (q_s[i]) if (q_s[i] - 1 > cyc) occ++;
      check("tx", {31'd0, tx}, {31'd0, exp_tx});
      check("busy", {31'd0, busy}, {31'd0, (q_s.size() > 0)});
      check("in_ready", {31'd0, in_ready}, {31'd0, (rst_n && occ < DEPTH)});
      check("frames_sent", {24'd0, frames_sent}, model_fs % 256);
    end
  end

  task automatic send(input logic [3:0] d, input logic [2:0] ep, input bit hold);
    int t = 0;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    err_pos  = ep;
    while (!in_ready && t < 2000) begin
      saw_not_ready = 1'b1;
      @(negedge clk); #1;
      t++;
    end
    if (t >= 2000) check("send_timeout", 32'd1, 32'd0);
    if (!hold) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_start();
    int t = 0;
    @(negedge clk);
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("start_timeout", 32'd1, 32'd0);
  endtask

  task automatic capture(output logic [6:0] bits);
    wait_start();
    repeat (CPB + CPB / 2) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < 7; i++) begin
      repeat (CPB) @(negedge clk);
      bits[i] = tx;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [6:0] got;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    err_pos  = 3'd7;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (20) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_frames_sent", {24'd0, frames_sent}, 32'd0);

    send(4'b1011, 3'd7, 1'b0);
    capture(got);
    check("wire_1011", {25'd0, got}, 32'h55);
    wait_idle();
    check("fs_after_1011", {24'd0, frames_sent}, 32'd1);

    send(4'b0001, 3'd3, 1'b0);
    capture(got);
    check("wire_0001_err3", {25'd0, got}, 32'h0F);
    wait_idle();
    check("fs_after_0001", {24'd0, frames_sent}, 32'd2);

    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(4'(i * 3 + 2), 3'(i % 8), (i != 5));
    wait_idle();
    check("burst_backpressure", {31'd0, saw_not_ready}, 32'd1);
    check("fs_after_burst", {24'd0, frames_sent}, 32'd8);

    send(4'b0110, 3'd7, 1'b0);
    wait_start();
    repeat (4 * CPB + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_fs", {24'd0, frames_sent}, 32'd0);

    send(4'b1100, 3'd7, 1'b0);
    capture(got);
    check("wire_1100", {25'd0, got}, 32'h61);
    wait_idle();
    check("fs_after_abort", {24'd0, frames_sent}, 32'd1);

    pulse_reset();
    send(4'b0000, 3'd7, 1'b0);
    capture(got);
    check("wire_0000", {25'd0, got}, 32'h00);
    wait_idle();
    send(4'b1111, 3'd7, 1'b0);
    capture(got);
    check("wire_1111", {25'd0, got}, 32'h7F);
    wait_idle();
    for (int i = 0; i < 254; i++) send(4'(i), 3'd7, (i != 253));
    wait_idle();
    check("fs_wrap", {24'd0, frames_sent}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
